// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the button conditioning path in front of the
// game-play logic. It holds the debounce FSM state encoding and the default
// timing constants, which assume a 100 MHz clock.
// Ports: none (package).
// ---------------------------------------------------------------------------
package game_pkg;

  // The four debounce FSM states. Their encodings are fixed because other
  // logic and waveform decoders rely on them.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned DEBOUNCE_10MS = 32'd1_000_000;   // 10 ms
  localparam int unsigned REPEAT_500MS  = 32'd50_000_000;  // 500 ms
  localparam int unsigned REPEAT_200MS  = 32'd20_000_000;  // 200 ms

endpackage

// File: rtl/btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One button channel. It contains a multi-flop synchroniser, a debounce FSM
// and an optional auto-repeat generator.
// Ports:
//   Clk100M - system clock; all logic runs on its rising edge
//   reset_n - asynchronous, active-low reset
//   raw     - raw button level (active-high, asynchronous)
//   level   - debounced level (registered)
//   pulse   - one-cycle strobe for a press or repeat event (registered)
// ---------------------------------------------------------------------------
module btn_channel
  import game_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_200MS,
  parameter int unsigned CNT_W           = 26
) (
  input  logic Clk100M,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  // A REPEAT_DELAY of 0 disables auto-repeat. The terminal-count constants
  // are guarded so that a zero parameter never underflows.
  localparam bit             REPEAT_EN = (REPEAT_DELAY != 0);
  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DLY_LAST =
    CNT_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PER_LAST =
    CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] rcnt_reg, rcnt_next;
  logic             rphase_reg, rphase_next;  // 0: initial delay, 1: period
  logic             level_reg, level_next;
  logic             pulse_reg, pulse_next;

  always_ff @(posedge Clk100M or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge Clk100M or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rcnt_reg   <= '0;
      rphase_reg <= 1'b0;
      level_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rcnt_reg   <= rcnt_next;
      rphase_reg <= rphase_next;
      level_reg  <= level_next;
      pulse_reg  <= pulse_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rcnt_next   = rcnt_reg;
    rphase_next = rphase_reg;
    level_next  = level_reg;
    pulse_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (s) begin
          if (DEB_LAST == '0) begin
            // Single-cycle debounce accepts the press on its first sample.
            state_next  = HELD;
            level_next  = 1'b1;
            pulse_next  = 1'b1;
            rcnt_next   = '0;
            rphase_next = 1'b0;
            cnt_next    = '0;
          end else begin
            state_next = PRESS_WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
      end

      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg >= DEB_LAST) begin
          state_next  = HELD;
          level_next  = 1'b1;
          pulse_next  = 1'b1;
          rcnt_next   = '0;
          rphase_next = 1'b0;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      HELD: begin
        // Release is checked first, so a release beats a repeat that is
        // due on the same cycle.
        if (!s) begin
          if (DEB_LAST == '0) begin
            state_next = IDLE;
            level_next = 1'b0;
            cnt_next   = '0;
          end else begin
            state_next = RELEASE_WAIT;
            cnt_next   = CNT_W'(1);
          end
        end else if (REPEAT_EN) begin
          // The >= compare stops the counter at its terminal count, so it
          // never wraps.
          if ((!rphase_reg && rcnt_reg >= DLY_LAST) ||
              ( rphase_reg && rcnt_reg >= PER_LAST)) begin
            pulse_next  = 1'b1;
            rcnt_next   = '0;
            rphase_next = 1'b1;
          end else begin
            rcnt_next = rcnt_reg + 1'b1;
          end
        end
      end

      RELEASE_WAIT: begin
        // rcnt and rphase are left unchanged here, so a short release
        // glitch only pauses the repeat cadence and does not restart it.
        if (s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg >= DEB_LAST) begin
          state_next = IDLE;
          level_next = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign level = level_reg;
  assign pulse = pulse_reg;

endmodule

// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse
// Button conditioning stage for the game-play logic. It builds N_BTN
// independent channels, each with a synchroniser, a debouncer and a
// press/auto-repeat pulse generator.
// Ports:
//   Clk100M   - system clock (100 MHz)
//   reset_n   - asynchronous, active-low reset
//   btn_raw   - raw, bouncy button levels (active-high)
//   btn_level - debounced levels
//   btn_pulse - one-cycle press/repeat strobes
// ---------------------------------------------------------------------------
module btn_debounce_pulse
  import game_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_200MS,
  parameter int unsigned CNT_W           = 26
) (
  input  logic             Clk100M,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W)
    ) u_chan (
      .Clk100M(Clk100M),
      .reset_n(reset_n),
      .raw    (btn_raw[gi]),
      .level  (btn_level[gi]),
      .pulse  (btn_pulse[gi])
    );
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_pulse
// Directed bench for btn_debounce_pulse with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10 and REPEAT_PERIOD=3. Edge e is the e-th rising edge after
// the stimulus is applied. Outputs are sampled 1 ns after each edge.
// ---------------------------------------------------------------------------
module tb_btn_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .N_BTN          (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (26)
  ) dut (
    .Clk100M  (clk),
    .reset_n  (rst_n),
    .btn_raw  (raw),
    .btn_level(level),
    .btn_pulse(pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    raw = 2'b00;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    raw   = 2'b00;
    rst_n = 1'b0;
    #1;
    total++;
    if (level !== 2'b00 || pulse !== 2'b00) begin
      bad++;
      $display("FAIL reset_async: level=%b pulse=%b want 00/00", level, pulse);
    end
    repeat (3) tick();
    total++;
    if (level !== 2'b00 || pulse !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold: level=%b pulse=%b want 00/00", level, pulse);
    end
    rst_n = 1'b1;
    settle(4);
    total++;
    if (level !== 2'b00 || pulse !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: level=%b pulse=%b want 00/00", level, pulse);
    end
  endtask

  // Press sampled at edge 0, release sampled at edge 8.
  task automatic test_clean_press();
    logic [1:0] exp_l, exp_p;
    raw = 2'b01;
    for (int e = 0; e <= 14; e++) begin
      if (e == 8) raw[0] = 1'b0;
      tick();
      exp_p = (e == 5) ? 2'b01 : 2'b00;
      exp_l = (e >= 5 && e < 13) ? 2'b01 : 2'b00;
      total++;
      if (pulse !== exp_p || level !== exp_l) begin
        bad++;
        $display("FAIL clean_press e=%0d: level=%b pulse=%b want %b/%b",
                 e, level, pulse, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int e = 0; e <= 15; e++) begin
      raw[0] = (e < 6) ? pat[e] : 1'b0;
      tick();
      total++;
      if (pulse !== 2'b00 || level !== 2'b00) begin
        bad++;
        $display("FAIL bounce e=%0d: level=%b pulse=%b want 00/00",
                 e, level, pulse);
      end
    end
  endtask

  task automatic test_repeat();
    logic exp_p;
    raw = 2'b10;
    for (int e = 0; e <= 30; e++) begin
      tick();
      exp_p = (e == 5) || (e >= 15 && ((e - 15) % 3) == 0);
      total++;
      if (pulse !== {exp_p, 1'b0} || level[1] !== (e >= 5)) begin
        bad++;
        $display("FAIL repeat e=%0d: level=%b pulse=%b want level1=%b pulse1=%b",
                 e, level, pulse, (e >= 5), exp_p);
      end
    end
    raw = 2'b00;
  endtask

  // A one-cycle low sampled at edge 7 makes the FSM see s=0 at edge 9 and
  // s=1 again at edge 10. Repeat counting stops for 2 edges, so the repeats
  // shift from 15/18/21 to 17/20/23.
  task automatic test_release_glitch();
    logic exp_p;
    for (int e = 0; e <= 24; e++) begin
      raw[0] = (e == 7) ? 1'b0 : 1'b1;
      tick();
      exp_p = (e == 5) || (e == 17) || (e == 20) || (e == 23);
      total++;
      if (pulse !== {1'b0, exp_p} || level !== {1'b0, e >= 5}) begin
        bad++;
        $display("FAIL glitch e=%0d: level=%b pulse=%b want level0=%b pulse0=%b",
                 e, level, pulse, (e >= 5), exp_p);
      end
    end
    raw = 2'b00;
  endtask

  task automatic test_reset_mid();
    raw = 2'b01;
    repeat (9) tick();
    total++;
    if (level !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_pre: level=%b want 01", level);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (level !== 2'b00 || pulse !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_async: level=%b pulse=%b want 00/00", level, pulse);
    end
    tick();
    tick();
    total++;
    if (level !== 2'b00 || pulse !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_hold: level=%b pulse=%b want 00/00", level, pulse);
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      total++;
      if (pulse !== {1'b0, e == 5} || level !== {1'b0, e >= 5}) begin
        bad++;
        $display("FAIL reset_mid_repress e=%0d: level=%b pulse=%b want level0=%b pulse0=%b",
                 e, level, pulse, (e >= 5), (e == 5));
      end
    end
    raw = 2'b00;
  endtask

  task automatic test_independence();
    logic [1:0] exp_v;
    raw = 2'b11;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp_v = (e == 5) ? 2'b11 : 2'b00;
      total++;
      if (pulse !== exp_v || level !== ((e >= 5) ? 2'b11 : 2'b00)) begin
        bad++;
        $display("FAIL both_press e=%0d: level=%b pulse=%b want pulse=%b",
                 e, level, pulse, exp_v);
      end
    end
    settle(12);
    for (int e = 0; e <= 9; e++) begin
      raw[0] = 1'b1;
      raw[1] = (e % 2 == 1);
      tick();
      total++;
      if (pulse !== {1'b0, e == 5} || level !== {1'b0, e >= 5}) begin
        bad++;
        $display("FAIL indep e=%0d: level=%b pulse=%b want level=0%b pulse=0%b",
                 e, level, pulse, (e >= 5), (e == 5));
      end
    end
    raw = 2'b00;
  endtask

  initial begin
    raw   = 2'b00;
    rst_n = 1'b0;
    test_reset();
    settle(12);
    test_clean_press();
    settle(12);
    test_bounce();
    settle(12);
    test_repeat();
    settle(12);
    test_release_glitch();
    settle(12);
    test_reset_mid();
    settle(12);
    test_independence();
    settle(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Button conditioning stage directly upstream of the game-play logic.
- Takes raw, bouncy, asynchronous push-button levels (up/down) and synchronises each to Clk100M.
- Debounces each button and emits a clean level plus a single-cycle press pulse (userUp/userDown).
- Optional auto-repeat: pulses continue at a fixed rate while a button stays held.

Parameters:
- N_BTN, 2, number of independent button channels.
- SYNC_STAGES, 2, flip-flop synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); >=1.
- REPEAT_DELAY, 50000000, cycles held before the first repeat pulse; 0 disables repeat.
- REPEAT_PERIOD, 20000000, cycles between subsequent repeat pulses; >=1 when repeat is enabled.
- CNT_W, 26, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- Clk100M  in  1  system clock, all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw button levels, active-high, asynchronous.
- btn_level  out  N_BTN  debounced level, registered.
- btn_pulse  out  N_BTN  one-cycle press/repeat strobe, registered.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- reset_n low: all synchroniser flops, counters, btn_level and btn_pulse go to 0; all channel FSMs go to IDLE.
- Channels are fully independent; no cross-channel priority or interlock.
- Synchroniser: btn_raw passes through SYNC_STAGES flops to give s (sync'd level).
- Per-channel FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE (level 0): s=1 -> PRESS_WAIT, cnt<=1.
  - PRESS_WAIT: s=0 -> IDLE, cnt<=0 (bounce rejected). s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, btn_pulse<=1, rcnt<=0. Otherwise cnt++.
  - HELD (level 1): s=0 -> RELEASE_WAIT, cnt<=1. Otherwise, if repeat is enabled, rcnt++. A repeat pulse fires when rcnt reaches REPEAT_DELAY-1 the first time, then every REPEAT_PERIOD cycles after that (rcnt reloads into the period phase).
  - RELEASE_WAIT: s=1 -> HELD, cnt<=0; no pulse, repeat phase is kept. s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0. Otherwise cnt++.
- DEBOUNCE_CYCLES=1: a transition is accepted on the first sampled cycle of s.
- btn_pulse is high for exactly one cycle per accepted press or repeat event; it is never asserted in IDLE, PRESS_WAIT or RELEASE_WAIT.
- Repeat counting is frozen during RELEASE_WAIT.
- Latency: a raw edge held stable from clock edge k gives btn_pulse and btn_level high after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. Release latency is symmetric.
- A repeat event and a release on the same cycle: release wins, no pulse.
- Counters saturate and never wrap: a bounded counter compare is mandatory.
- Button held while reset deasserts: treated as a new press, so the pulse appears after the normal latency.
- Reset asserted mid-debounce or mid-repeat: immediate clear, with no pulse on exit.

Decomposition:
- Shared package game_pkg: state encoding localparams (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3) and the default timing constants (DEBOUNCE_10MS, REPEAT_500MS, REPEAT_200MS).
- Sub-module btn_channel: one synchroniser, FSM and counters per button. Instantiated N_BTN times via generate. The top level only fans out ports and parameters.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Clean press: btn_raw[0] 0->1 sampled at edge 0 and held -> btn_pulse[0]=1 for exactly one cycle after edge 5, btn_level[0]=1 from edge 5; btn_raw[0] -> 0 -> btn_level[0]=0 after 5 more edges, no pulse.
2. Bounce reject: btn_raw[0] pattern 1,1,0,1,1,0 then 0 -> btn_level and btn_pulse stay 0 throughout.
3. Auto-repeat: hold btn_raw[1] for 30 cycles -> pulses at cycles 5, 15, 18, 21, 24, 27, 30 relative to edge 0; btn_level[1] stays 1.
4. Release glitch: while HELD, single-cycle 0 on btn_raw[0] -> btn_level stays 1, no extra pulse, repeat cadence preserved.
5. Reset mid-operation: assert reset_n=0 during HELD with btn_raw=1 -> outputs 0 immediately (asynchronous); deassert with btn held -> one pulse after 5 edges.
6. Independence: both buttons pressed on the same edge -> both channels pulse on the same cycle; bouncing btn_raw[1] does not affect channel 0 timing.
